// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the 8-entry one-hot register file.
// Also reused by the decoder_3to8 bench for one-hot checks.
package reg_file_pkg;

    localparam int NREG      = 8;
    localparam int ADDR_W    = 3;
    localparam int DEF_WIDTH = 8;

    localparam logic [NREG-1:0] REG_NONE = 8'h00;

    function automatic logic is_onehot8(input logic [NREG-1:0] sel);
        return ($countones(sel) == 1);
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One registered read port: address mux, write-first bypass, valid mask.
// Latency 1 cycle; no backpressure, data holds while i_rd_en is low.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic                        i_rd_en,
    input  logic [ADDR_W-1:0]           i_rd_addr,
    input  logic [NREG-1:0][WIDTH-1:0]  i_regs,
    input  logic [NREG-1:0]             i_reg_valid,
    input  logic                        i_wr_legal,
    input  logic [NREG-1:0]             i_wr_sel,
    input  logic [WIDTH-1:0]            i_wr_data,
    output logic [WIDTH-1:0]            o_rd_data,
    output logic                        o_rd_valid
);

    logic             w_bypass;
    logic [WIDTH-1:0] w_rd_next;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    // Reads see the pre-clear view, so a pending Clear is deliberately not consulted here.
    always_comb begin
        w_bypass  = i_wr_legal && i_wr_sel[i_rd_addr];
        w_rd_next = '0;
        if (w_bypass) begin
            w_rd_next = i_wr_data;
        end else if (i_reg_valid[i_rd_addr]) begin
            w_rd_next = i_regs[i_rd_addr];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_rd_next;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/reg_file_8x_onehot.sv
// Eight-entry register file with one-hot write select, two registered read ports.
// Read latency 1 cycle; no backpressure. Non-one-hot write requests set a sticky error.
module reg_file_8x_onehot
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_wr_enable,
    input  logic [NREG-1:0]    i_wr_sel,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_clear,
    input  logic               i_rd_en_a,
    input  logic [ADDR_W-1:0]  i_rd_addr_a,
    input  logic               i_rd_en_b,
    input  logic [ADDR_W-1:0]  i_rd_addr_b,
    output logic [WIDTH-1:0]   o_rd_data_a,
    output logic               o_rd_valid_a,
    output logic [WIDTH-1:0]   o_rd_data_b,
    output logic               o_rd_valid_b,
    output logic [NREG-1:0]    o_reg_valid,
    output logic               o_sel_error
);

    logic [NREG-1:0][WIDTH-1:0] r_regs;
    logic [NREG-1:0]            r_reg_valid;
    logic                       r_sel_error;
    logic                       w_sel_onehot;
    logic                       w_wr_legal;
    logic                       w_wr_illegal;

    assign w_sel_onehot = is_onehot8(i_wr_sel);
    assign w_wr_legal   = i_wr_enable &&  w_sel_onehot;
    assign w_wr_illegal = i_wr_enable && !w_sel_onehot;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_regs <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_legal && i_wr_sel[i]) begin
                    r_regs[i] <= i_wr_data;
                end
            end
        end
    end

    // A legal write beats Clear; an illegal write beats Clear on the error flag.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_reg_valid <= REG_NONE;
            r_sel_error <= 1'b0;
        end else begin
            if (i_clear) begin
                r_reg_valid <= w_wr_legal ? i_wr_sel : REG_NONE;
            end else if (w_wr_legal) begin
                r_reg_valid <= r_reg_valid | i_wr_sel;
            end
            if (w_wr_illegal) begin
                r_sel_error <= 1'b1;
            end else if (i_clear) begin
                r_sel_error <= 1'b0;
            end
        end
    end

    reg_file_read_port #(.WIDTH(WIDTH)) u_port_a (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_rd_en     (i_rd_en_a),
        .i_rd_addr   (i_rd_addr_a),
        .i_regs      (r_regs),
        .i_reg_valid (r_reg_valid),
        .i_wr_legal  (w_wr_legal),
        .i_wr_sel    (i_wr_sel),
        .i_wr_data   (i_wr_data),
        .o_rd_data   (o_rd_data_a),
        .o_rd_valid  (o_rd_valid_a)
    );

    reg_file_read_port #(.WIDTH(WIDTH)) u_port_b (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_rd_en     (i_rd_en_b),
        .i_rd_addr   (i_rd_addr_b),
        .i_regs      (r_regs),
        .i_reg_valid (r_reg_valid),
        .i_wr_legal  (w_wr_legal),
        .i_wr_sel    (i_wr_sel),
        .i_wr_data   (i_wr_data),
        .o_rd_data   (o_rd_data_b),
        .o_rd_valid  (o_rd_valid_b)
    );

    assign o_reg_valid = r_reg_valid;
    assign o_sel_error = r_sel_error;

endmodule

// File: tb/tb_reg_file_8x_onehot.sv
// Bench for reg_file_8x_onehot: directed plan then random traffic against an array model.
// Inputs change and outputs are checked on the falling edge.
module tb_reg_file_8x_onehot;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       wr_enable;
    logic [7:0] wr_sel;
    logic [7:0] wr_data;
    logic       clear;
    logic       rd_en_a, rd_en_b;
    logic [2:0] rd_addr_a, rd_addr_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic       rd_valid_a, rd_valid_b;
    logic [7:0] reg_valid;
    logic       sel_error;

    always #5 clock = ~clock;

    reg_file_8x_onehot #(.WIDTH(8)) dut (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_wr_enable  (wr_enable),
        .i_wr_sel     (wr_sel),
        .i_wr_data    (wr_data),
        .i_clear      (clear),
        .i_rd_en_a    (rd_en_a),
        .i_rd_addr_a  (rd_addr_a),
        .i_rd_en_b    (rd_en_b),
        .i_rd_addr_b  (rd_addr_b),
        .o_rd_data_a  (rd_data_a),
        .o_rd_valid_a (rd_valid_a),
        .o_rd_data_b  (rd_data_b),
        .o_rd_valid_b (rd_valid_b),
        .o_reg_valid  (reg_valid),
        .o_sel_error  (sel_error)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain arrays of contents and written flags.
    logic [7:0] m_val [8];
    logic       m_written [8];
    logic       m_err;
    logic [7:0] m_da, m_db;
    logic       m_va, m_vb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sel_index(input logic [7:0] s);
        int cnt = 0;
        int idx = -1;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) begin
                cnt++;
                idx = i;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    function automatic logic [7:0] model_read(input int widx, input logic [2:0] addr);
        if (widx == int'(addr)) return wr_data;
        if (m_written[addr])    return m_val[addr];
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_val[i]     = 8'h00;
            m_written[i] = 1'b0;
        end
        m_err = 1'b0;
        m_da  = 8'h00;
        m_db  = 8'h00;
        m_va  = 1'b0;
        m_vb  = 1'b0;
    endtask

    // Applies the current inputs to the model as the coming rising edge will.
    task automatic model_edge();
        int widx;
        widx = wr_enable ? sel_index(wr_sel) : -1;
        m_va = rd_en_a;
        m_vb = rd_en_b;
        if (rd_en_a) m_da = model_read(widx, rd_addr_a);
        if (rd_en_b) m_db = model_read(widx, rd_addr_b);
        if (clear) begin
            for (int i = 0; i < 8; i++) m_written[i] = 1'b0;
        end
        if (widx >= 0) begin
            m_val[widx]     = wr_data;
            m_written[widx] = 1'b1;
        end
        if (wr_enable && widx < 0) m_err = 1'b1;
        else if (clear)            m_err = 1'b0;
    endtask

    function automatic logic [7:0] model_valid_bits();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_written[i];
        return v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " rd_valid_a"}, 32'(rd_valid_a), 32'(m_va));
        chk({tag, " rd_data_a"},  32'(rd_data_a),  32'(m_da));
        chk({tag, " rd_valid_b"}, 32'(rd_valid_b), 32'(m_vb));
        chk({tag, " rd_data_b"},  32'(rd_data_b),  32'(m_db));
        chk({tag, " reg_valid"},  32'(reg_valid),  32'(model_valid_bits()));
        chk({tag, " sel_error"},  32'(sel_error),  32'(m_err));
    endtask

    // Called on a falling edge: drive, clock once, check on the next falling edge.
    task automatic cycle(input string tag, input logic we, input logic [7:0] sel,
                         input logic [7:0] wd, input logic clr,
                         input logic ea, input logic [2:0] aa,
                         input logic eb, input logic [2:0] ab);
        wr_enable = we;  wr_sel = sel;  wr_data = wd;  clear = clr;
        rd_en_a = ea;  rd_addr_a = aa;  rd_en_b = eb;  rd_addr_b = ab;
        model_edge();
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] rsel;
        reset_n = 1'b0;
        wr_enable = 0; wr_sel = 0; wr_data = 0; clear = 0;
        rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        reset_n = 1'b1;

        cycle("idle",        0, 8'h00, 8'h00, 0, 0, 3'd0, 0, 3'd0);
        cycle("rd_invalid",  0, 8'h00, 8'h00, 0, 1, 3'd3, 0, 3'd0);
        cycle("wr_r2",       1, 8'h04, 8'hA5, 0, 0, 3'd0, 0, 3'd0);
        cycle("rd_r2",       0, 8'h00, 8'h00, 0, 1, 3'd2, 0, 3'd0);
        cycle("bypass_r7",   1, 8'h80, 8'h3C, 0, 1, 3'd7, 1, 3'd7);
        cycle("illegal_two", 1, 8'h06, 8'h77, 0, 1, 3'd1, 1, 3'd2);
        cycle("clear",       0, 8'h00, 8'h00, 1, 0, 3'd0, 0, 3'd0);
        cycle("rewr_r2",     1, 8'h04, 8'hA5, 0, 0, 3'd0, 0, 3'd0);
        cycle("clr_wr_r0",   1, 8'h01, 8'h5A, 1, 1, 3'd2, 1, 3'd0);
        cycle("rd_cleared",  0, 8'h00, 8'h00, 0, 1, 3'd2, 1, 3'd0);
        cycle("clr_illegal", 1, 8'h00, 8'h11, 1, 0, 3'd0, 0, 3'd0);
        cycle("hold_data",   0, 8'hFF, 8'h22, 0, 0, 3'd5, 0, 3'd5);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                7:       rsel = 8'h00;
                8, 9:    rsel = 8'($urandom);
                default: rsel = 8'(1 << $urandom_range(0, 7));
            endcase
            cycle("random", ($urandom % 4) != 0, rsel, 8'($urandom),
                  ($urandom % 16) == 0,
                  1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
        end

        // Asynchronous reset landing while a read result is in flight.
        wr_enable = 1; wr_sel = 8'h08; wr_data = 8'hC3; clear = 0;
        rd_en_a = 1; rd_addr_a = 3'd3; rd_en_b = 1; rd_addr_b = 3'd3;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        cycle("post_rst", 0, 8'h00, 8'h00, 0, 0, 3'd3, 0, 3'd3);
        cycle("post_rd",  0, 8'h00, 8'h00, 0, 1, 3'd3, 1, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
